// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - command codes, state encodings and status bits shared by the DES sweep path
package des_pkg;

  typedef enum logic [1:0] {
    CMD_READ_REGION = 2'd0,
    CMD_START       = 2'd1,
    CMD_TEST_MODE   = 2'd2,
    CMD_RESTART     = 2'd3
  } cmd_code_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_REL
  } hs_state_e;

  typedef enum logic [3:0] {
    SEQ_IDLE,
    SEQ_RGN,
    SEQ_START,
    SEQ_WAIT_DONE,
    SEQ_SETTLE,
    SEQ_STORE,
    SEQ_TOUT,
    SEQ_RST,
    SEQ_NEXT,
    SEQ_DONE
  } seq_state_e;

  localparam logic [1:0] STATUS_OK = 2'b00;
  localparam int STATUS_ABORT_BIT = 0;
  localparam int STATUS_TOUT_BIT  = 1;

  function automatic logic [31:0] cmd_word(input cmd_code_e code);
    return {30'd0, code};
  endfunction

endpackage

// File: rtl/des_cmd_handshake.sv
// rtl/des_cmd_handshake.sv - 4-phase REQ/REL command master towards the DES wrapper
module des_cmd_handshake
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_go,
  input  cmd_code_e   cmd_code,
  output logic        cmd_done,
  output logic [31:0] cmd,
  output logic        cmd_valid,
  input  logic        cmd_read
);

  hs_state_e state, state_next;
  cmd_code_e code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HS_IDLE;
      code_q <= CMD_READ_REGION;
    end else begin
      state <= state_next;
      if (state == HS_IDLE && cmd_go)
        code_q <= cmd_code;
    end
  end

  // cmd_done fires as the wrapper releases cmd_read, so the caller advances on the same edge
  always_comb begin
    state_next = state;
    cmd_done   = 1'b0;
    case (state)
      HS_IDLE: if (cmd_go) state_next = HS_REQ;
      HS_REQ:  if (cmd_read) state_next = HS_REL;
      HS_REL: begin
        if (!cmd_read) begin
          state_next = HS_IDLE;
          cmd_done   = 1'b1;
        end
      end
      default: state_next = HS_IDLE;
    endcase
  end

  assign cmd_valid = (state == HS_REQ);
  assign cmd       = cmd_word(code_q);

endmodule

// File: rtl/des_sweep_sequencer.sv
// rtl/des_sweep_sequencer.sv - sweeps a range of regions through the DES wrapper and queues results
module des_sweep_sequencer
  import des_pkg::*;
#(
  parameter int          REGION_W       = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sweep_start,
  input  logic [REGION_W-1:0] region_first,
  input  logic [REGION_W-1:0] region_count,
  input  logic                abort,
  output logic                busy,
  output logic                sweep_done,
  output logic [1:0]          sweep_status,
  output logic [31:0]         cmd,
  output logic                cmd_valid,
  output logic [31:0]         region,
  input  logic                cmd_read,
  input  logic                des_done,
  input  logic [63:0]         des_counter,
  input  logic [63:0]         des_ciphertext,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [REGION_W-1:0] res_region,
  output logic [63:0]         res_counter,
  output logic [63:0]         res_ciphertext,
  output logic                res_timeout
);

  localparam logic [REGION_W-1:0] REGION_ONE = {{(REGION_W-1){1'b0}}, 1'b1};

  seq_state_e          state, state_next;
  logic [REGION_W-1:0] cur, left;
  logic                abort_q;
  logic [31:0]         wd_count;
  logic                hs_go, hs_done;
  cmd_code_e           hs_code;
  logic                res_free, wd_expired;

  des_cmd_handshake u_hs (
    .clk       (clk),
    .rst       (rst),
    .cmd_go    (hs_go),
    .cmd_code  (hs_code),
    .cmd_done  (hs_done),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_read  (cmd_read)
  );

  assign res_free   = !res_valid || res_ready;
  assign wd_expired = (TIMEOUT_CYCLES != 32'd0) && (wd_count == TIMEOUT_CYCLES - 32'd1);
  assign busy       = (state != SEQ_IDLE);
  assign region     = 32'(cur);

  always_comb begin
    state_next = state;
    hs_go      = 1'b0;
    hs_code    = CMD_READ_REGION;
    case (state)
      SEQ_IDLE: if (sweep_start) state_next = (region_count == '0) ? SEQ_DONE : SEQ_RGN;
      SEQ_RGN: begin
        hs_go   = 1'b1;
        hs_code = CMD_READ_REGION;
        if (hs_done) state_next = SEQ_START;
      end
      SEQ_START: begin
        hs_go   = 1'b1;
        hs_code = CMD_START;
        if (hs_done) state_next = SEQ_WAIT_DONE;
      end
      SEQ_WAIT_DONE: begin
        if (des_done)        state_next = SEQ_SETTLE;
        else if (wd_expired) state_next = SEQ_TOUT;
        else if (abort_q)    state_next = SEQ_RST;
      end
      // the wrapper's counter register lags done by one cycle
      SEQ_SETTLE: state_next = SEQ_STORE;
      SEQ_STORE:  if (res_free) state_next = SEQ_RST;
      SEQ_TOUT:   if (res_free) state_next = SEQ_RST;
      SEQ_RST: begin
        hs_go   = 1'b1;
        hs_code = CMD_RESTART;
        if (hs_done) state_next = SEQ_NEXT;
      end
      SEQ_NEXT: state_next = (left == REGION_ONE || abort_q) ? SEQ_DONE : SEQ_RGN;
      SEQ_DONE: state_next = SEQ_IDLE;
      default:  state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= SEQ_IDLE;
      cur            <= '0;
      left           <= '0;
      abort_q        <= 1'b0;
      wd_count       <= 32'd0;
      sweep_done     <= 1'b0;
      sweep_status   <= STATUS_OK;
      res_valid      <= 1'b0;
      res_region     <= '0;
      res_counter    <= 64'd0;
      res_ciphertext <= 64'd0;
      res_timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      sweep_done <= (state == SEQ_DONE);
      wd_count   <= (state == SEQ_WAIT_DONE) ? wd_count + 32'd1 : 32'd0;

      if (state == SEQ_IDLE && sweep_start) begin
        cur          <= region_first;
        left         <= region_count;
        sweep_status <= STATUS_OK;
      end
      if (state == SEQ_NEXT) begin
        cur  <= cur + REGION_ONE;
        left <= left - REGION_ONE;
      end

      if (state == SEQ_DONE) begin
        abort_q <= 1'b0;
      end else if (state != SEQ_IDLE && abort) begin
        abort_q                        <= 1'b1;
        sweep_status[STATUS_ABORT_BIT] <= 1'b1;
      end

      // a load in the same cycle as a consume wins, keeping res_valid high
      if (res_valid && res_ready)
        res_valid <= 1'b0;
      if (state == SEQ_STORE && res_free) begin
        res_region     <= cur;
        res_counter    <= des_counter;
        res_ciphertext <= des_ciphertext;
        res_timeout    <= 1'b0;
        res_valid      <= 1'b1;
      end
      if (state == SEQ_TOUT && res_free) begin
        res_region                    <= cur;
        res_timeout                   <= 1'b1;
        res_valid                     <= 1'b1;
        sweep_status[STATUS_TOUT_BIT] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_des_sweep_sequencer.sv
// tb/tb_des_sweep_sequencer.sv - randomized self-checking bench with a behavioural DES wrapper model
module tb_des_sweep_sequencer;

  localparam int          LATENCY = 20;
  localparam logic [31:0] WD      = 32'd50;

  typedef struct packed {
    logic [15:0] region;
    logic [63:0] counter;
    logic [63:0] ct;
    logic        tout;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sweep_start, abort, busy, sweep_done;
  logic [15:0] region_first, region_count;
  logic [1:0]  sweep_status;
  logic [31:0] cmd, region;
  logic        cmd_valid, cmd_read, des_done;
  logic [63:0] des_counter, des_ciphertext;
  logic        res_valid, res_ready, res_timeout;
  logic [15:0] res_region;
  logic [63:0] res_counter, res_ciphertext;

  int passed = 0;
  int total  = 0;

  logic [63:0] key;
  bit          never_done;
  int          hs_cmd[$], exp_cmd[$];
  logic [31:0] hs_region[$], exp_rgn[$];
  res_t        got[$], exp_q[$];

  always #5 clk = ~clk;

  des_sweep_sequencer #(.REGION_W(16), .TIMEOUT_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .sweep_start(sweep_start), .region_first(region_first),
    .region_count(region_count), .abort(abort), .busy(busy), .sweep_done(sweep_done),
    .sweep_status(sweep_status), .cmd(cmd), .cmd_valid(cmd_valid), .region(region),
    .cmd_read(cmd_read), .des_done(des_done), .des_counter(des_counter),
    .des_ciphertext(des_ciphertext), .res_valid(res_valid), .res_ready(res_ready),
    .res_region(res_region), .res_counter(res_counter), .res_ciphertext(res_ciphertext),
    .res_timeout(res_timeout)
  );

  function automatic logic [63:0] ctr_of(input logic [15:0] r);
    return {key[63:32] ^ {16'h0, r}, {16'h0, r} * 32'd7919};
  endfunction

  function automatic logic [63:0] ct_of(input logic [15:0] r);
    return key ^ ({48'd0, r} * 64'h9E3779B97F4A7C15);
  endfunction

  // Wrapper model: answers handshakes, raises done LATENCY cycles after START, counter lags done
  initial begin : wrapper_model
    int          timer;
    bit          running, load_ctr;
    logic [15:0] rgn_sel;
    timer = 0; running = 0; load_ctr = 0; rgn_sel = '0;
    cmd_read = 0; des_done = 0; des_counter = '0; des_ciphertext = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cmd_read = 0; des_done = 0; running = 0; load_ctr = 0;
        continue;
      end
      if (load_ctr) begin
        des_counter = ctr_of(rgn_sel);
        load_ctr = 0;
      end
      if (running) begin
        timer--;
        if (timer == 0) begin
          running = 0; des_done = 1; load_ctr = 1;
          des_ciphertext = ct_of(rgn_sel);
        end
      end
      if (cmd_valid && !cmd_read) begin
        cmd_read = 1;
        hs_cmd.push_back(int'(cmd));
        hs_region.push_back(region);
        case (cmd)
          32'd0: rgn_sel = region[15:0];
          32'd1: begin des_done = 0; running = !never_done; timer = LATENCY; end
          32'd3: begin des_done = 0; running = 0; end
          default: ;
        endcase
      end else if (!cmd_valid && cmd_read) begin
        cmd_read = 0;
      end
    end
  end

  initial begin : collector
    res_t r;
    forever begin
      @(negedge clk); #1;
      if (!rst && res_valid && res_ready) begin
        r.region = res_region; r.counter = res_counter; r.ct = res_ciphertext; r.tout = res_timeout;
        got.push_back(r);
      end
    end
  end

  initial begin : global_limit
    #1000000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

  task automatic clear_logs();
    got.delete(); hs_cmd.delete(); hs_region.delete();
    key = {$urandom, $urandom};
  endtask

  // Reference: every region yields one result and the command triple READ_REGION, START, RESTART
  task automatic model_sweep(input logic [15:0] first, input int n);
    logic [15:0] r;
    exp_q.delete(); exp_cmd.delete(); exp_rgn.delete();
    for (int i = 0; i < n; i++) begin
      r = first + 16'(i);
      exp_q.push_back({r, ctr_of(r), ct_of(r), 1'b0});
      exp_cmd.push_back(0); exp_cmd.push_back(1); exp_cmd.push_back(3);
      repeat (3) exp_rgn.push_back({16'h0, r});
    end
  endtask

  task automatic kick(input logic [15:0] first, input logic [15:0] n);
    @(negedge clk);
    region_first = first; region_count = n; sweep_start = 1;
    @(negedge clk);
    sweep_start = 0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (sweep_done) seen = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk); #1;
    total++; if ({busy, sweep_done, sweep_status} !== 4'b0) $display("FAIL reset_ctrl got %b want 0000", {busy, sweep_done, sweep_status}); else passed++;
    total++; if ({cmd_valid, cmd, region} !== 65'b0) $display("FAIL reset_cmd got %h want 0", {cmd_valid, cmd, region}); else passed++;
    total++; if ({res_valid, res_region, res_counter, res_ciphertext, res_timeout} !== 146'b0) $display("FAIL reset_res got %h want 0", {res_valid, res_region, res_counter, res_ciphertext, res_timeout}); else passed++;
  endtask

  task automatic test_nominal();
    bit seen;
    clear_logs();
    res_ready = 1;
    model_sweep(16'd5, 3);
    kick(16'd5, 16'd3);
    total++; if (busy !== 1'b1) $display("FAIL nominal_busy got %b want 1", busy); else passed++;
    wait_done(2000, seen);
    total++; if (!seen) $display("FAIL nominal_done got 0 want 1"); else passed++;
    total++; if (sweep_status !== 2'b00) $display("FAIL nominal_status got %b want 00", sweep_status); else passed++;
    total++; if (got.size() != 3) $display("FAIL nominal_result_count got %0d want 3", got.size()); else passed++;
    for (int i = 0; i < got.size() && i < 3; i++) begin
      total++; if (got[i] !== exp_q[i]) $display("FAIL nominal_result%0d got %h want %h", i, got[i], exp_q[i]); else passed++;
    end
    total++; if (hs_cmd.size() != 9) $display("FAIL nominal_handshakes got %0d want 9", hs_cmd.size()); else passed++;
    for (int i = 0; i < hs_cmd.size() && i < 9; i++) begin
      total++; if (hs_cmd[i] != exp_cmd[i] || hs_region[i] !== exp_rgn[i]) $display("FAIL nominal_cmd%0d got %0d/%h want %0d/%h", i, hs_cmd[i], hs_region[i], exp_cmd[i], exp_rgn[i]); else passed++;
    end
    total++; if (busy !== 1'b0) $display("FAIL nominal_idle_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_zero_count();
    int cyc;
    bit seen, valid_seen;
    clear_logs();
    @(negedge clk);
    region_first = 16'h1234; region_count = 16'd0; sweep_start = 1;
    cyc = 0; seen = 0; valid_seen = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      sweep_start = 0;
      cyc++;
      if (cmd_valid) valid_seen = 1;
      if (sweep_done) seen = 1;
    end
    total++; if (!seen || cyc != 2) $display("FAIL zero_latency got %0d want 2", cyc); else passed++;
    total++; if (valid_seen || hs_cmd.size() != 0) $display("FAIL zero_no_cmd got %0d handshakes want 0", hs_cmd.size()); else passed++;
    total++; if (sweep_status !== 2'b00) $display("FAIL zero_status got %b want 00", sweep_status); else passed++;
    total++; if (got.size() != 0) $display("FAIL zero_results got %0d want 0", got.size()); else passed++;
  endtask

  task automatic test_random();
    bit          seen;
    logic [15:0] first;
    int          n;
    for (int it = 0; it < 3; it++) begin
      clear_logs();
      first = (it == 0) ? 16'hFFFE : 16'($urandom);
      n = $urandom_range(1, 4);
      model_sweep(first, n);
      kick(first, 16'(n));
      wait_done(3000, seen);
      total++; if (!seen || sweep_status !== 2'b00) $display("FAIL rand%0d_done got %b/%b want 1/00", it, seen, sweep_status); else passed++;
      total++; if (got.size() != n || hs_cmd.size() != 3 * n) $display("FAIL rand%0d_counts got %0d/%0d want %0d/%0d", it, got.size(), hs_cmd.size(), n, 3 * n); else passed++;
      for (int i = 0; i < got.size() && i < n; i++) begin
        total++; if (got[i] !== exp_q[i]) $display("FAIL rand%0d_result%0d got %h want %h", it, i, got[i], exp_q[i]); else passed++;
      end
      for (int i = 0; i < hs_cmd.size() && i < 3 * n; i++) begin
        total++; if (hs_cmd[i] != exp_cmd[i] || hs_region[i] !== exp_rgn[i]) $display("FAIL rand%0d_cmd%0d got %0d/%h want %0d/%h", it, i, hs_cmd[i], hs_region[i], exp_cmd[i], exp_rgn[i]); else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit          seen;
    int          k;
    logic [15:0] first;
    clear_logs();
    first = 16'($urandom);
    model_sweep(first, 3);
    res_ready = 1;
    kick(first, 16'd3);
    k = 0;
    while (got.size() == 0 && k < 500) begin @(negedge clk); #2; k++; end
    total++; if (got.size() != 1) $display("FAIL bp_first got %0d results want 1", got.size()); else passed++;
    @(posedge clk); #1;
    res_ready = 0;
    repeat (100) @(negedge clk);
    #1;
    total++; if (res_valid !== 1'b1 || res_region !== first + 16'd1) $display("FAIL bp_held got %b/%h want 1/%h", res_valid, res_region, first + 16'd1); else passed++;
    total++; if (hs_cmd.size() != 8 || got.size() != 1) $display("FAIL bp_stall got %0d cmds/%0d results want 8/1", hs_cmd.size(), got.size()); else passed++;
    res_ready = 1;
    wait_done(2000, seen);
    total++; if (!seen || got.size() != 3) $display("FAIL bp_finish got %b/%0d want 1/3", seen, got.size()); else passed++;
    for (int i = 0; i < got.size() && i < 3; i++) begin
      total++; if (got[i] !== exp_q[i]) $display("FAIL bp_result%0d got %h want %h", i, got[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_watchdog();
    bit          seen, marked;
    int          t0, t1, cyc;
    logic [15:0] first;
    clear_logs();
    never_done = 1;
    res_ready = 1;
    first = 16'($urandom);
    kick(first, 16'd1);
    marked = 0; t0 = -1; t1 = -1; cyc = 0;
    while (t1 < 0 && cyc < 400) begin
      @(negedge clk); #1;
      cyc++;
      if (!marked && hs_cmd.size() == 2 && !cmd_read) begin marked = 1; t0 = cyc; end
      if (marked && res_valid) t1 = cyc;
    end
    total++; if (t1 < 0 || t1 - t0 != 52) $display("FAIL wd_latency got %0d want 52", t1 - t0); else passed++;
    total++; if (res_timeout !== 1'b1 || res_region !== first) $display("FAIL wd_result got %b/%h want 1/%h", res_timeout, res_region, first); else passed++;
    wait_done(500, seen);
    total++; if (!seen || sweep_status !== 2'b10) $display("FAIL wd_status got %b/%b want 1/10", seen, sweep_status); else passed++;
    total++; if (hs_cmd.size() != 3 || hs_cmd[hs_cmd.size() - 1] != 3) $display("FAIL wd_restart got %0d cmds want 3 ending in 3", hs_cmd.size()); else passed++;
    never_done = 0;
  endtask

  task automatic test_abort();
    bit          seen;
    int          k;
    logic [15:0] first;
    clear_logs();
    res_ready = 1;
    first = 16'($urandom);
    kick(first, 16'd4);
    k = 0;
    while (!(hs_cmd.size() == 5 && !cmd_read) && k < 500) begin @(negedge clk); #1; k++; end
    repeat (5) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    wait_done(500, seen);
    total++; if (!seen || sweep_status !== 2'b01) $display("FAIL abort_status got %b/%b want 1/01", seen, sweep_status); else passed++;
    total++; if (got.size() != 1 || got[0].region !== first) $display("FAIL abort_results got %0d want 1 for region %h", got.size(), first); else passed++;
    total++; if (hs_cmd.size() != 6 || hs_cmd[hs_cmd.size() - 1] != 3 || hs_region[hs_region.size() - 1] !== {16'h0, first + 16'd1}) $display("FAIL abort_restart got %0d cmds want 6 ending RESTART of %h", hs_cmd.size(), first + 16'd1); else passed++;
  endtask

  task automatic test_back_to_back();
    bit          seen;
    logic [15:0] first;
    clear_logs();
    res_ready = 1;
    first = 16'($urandom);
    model_sweep(first, 2);
    kick(first, 16'd2);
    repeat (10) @(negedge clk);
    region_first = first + 16'd100; region_count = 16'd4; sweep_start = 1;
    @(negedge clk);
    sweep_start = 0;
    wait_done(2000, seen);
    total++; if (!seen || got.size() != 2) $display("FAIL b2b_count got %b/%0d want 1/2", seen, got.size()); else passed++;
    for (int i = 0; i < got.size() && i < 2; i++) begin
      total++; if (got[i] !== exp_q[i]) $display("FAIL b2b_result%0d got %h want %h", i, got[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_logs();
    kick(16'd40, 16'd2);
    k = 0;
    while (!cmd_valid && k < 20) begin @(negedge clk); #1; k++; end
    total++; if (cmd_valid !== 1'b1) $display("FAIL rstmid_req got %b want 1", cmd_valid); else passed++;
    #2 rst = 1;
    #1;
    total++; if ({cmd_valid, busy, res_valid} !== 3'b000) $display("FAIL rstmid_async got %b want 000", {cmd_valid, busy, res_valid}); else passed++;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    test_nominal();
  endtask

  initial begin
    rst = 1; sweep_start = 0; abort = 0; res_ready = 1;
    region_first = '0; region_count = '0; never_done = 0; key = '0;
    test_reset();
    test_nominal();
    test_zero_count();
    test_random();
    test_backpressure();
    test_watchdog();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
